modn_time_counter: RTL
======================

Name: modn_time_counter

Overview:
- Parametrised successor to the fixed 0..59 clock counter: modulo-MODULUS up counter with debounced up/down adjust buttons, parallel preset and registered wrap pulses.
- One instance per clock field (seconds, minutes, hours).
- Instances cascade: carry_out of one stage feeds tick_in of the next.
- Provides a BCD split of the count for the display driver.

Parameters:
- MODULUS, 60, count range 0..MODULUS-1; legal 2..100.
- WIDTH, 6, count width; must satisfy 2**WIDTH >= MODULUS.
- DEBOUNCE, 4, number of clk cycles a synchronised button level must stay stable before it is accepted; legal 1..255.
- CARRY_ON_ADJUST, 0, when 1, adjust-induced wraps also pulse carry_out/borrow_out.

Ports:
- clk  in  1  system clock, all state on rising edge.
- clear  in  1  asynchronous active-high reset.
- tick_in  in  1  one-cycle count enable (1 Hz strobe or lower-stage carry).
- keep  in  1  hold: freezes count, drops tick and adjust events.
- adj_up  in  1  raw asynchronous push-button, increment.
- adj_down  in  1  raw asynchronous push-button, decrement.
- load  in  1  synchronous preset strobe.
- load_val  in  WIDTH  preset value.
- digits  out  WIDTH  current count.
- bcd_tens  out  4  tens digit of digits.
- bcd_ones  out  4  ones digit of digits.
- carry_out  out  1  one-cycle pulse on upward wrap MODULUS-1 -> 0.
- borrow_out  out  1  one-cycle pulse on downward wrap 0 -> MODULUS-1; only when CARRY_ON_ADJUST=1.

Behaviour:
- Reset (clear=1, asynchronous, active-high): digits=0, bcd_tens=0, bcd_ones=0, carry_out=0, borrow_out=0.
- Reset also clears synchronisers, debounce counters and edge-detect state.
- Button path, per button:
  - 2-FF synchroniser.
  - Debounce counter: the stable level updates only after DEBOUNCE consecutive cycles of an identical synchronised value.
  - A rising edge of the stable level produces a one-cycle adjust event.
  - Latency from the raw edge to the event is 2+DEBOUNCE cycles.
  - Releasing the button produces no event.
- Update priority each cycle:
  1. load
  2. keep
  3. net step
- load=1:
  - load_val < MODULUS: digits <= load_val.
  - load_val >= MODULUS: load ignored, digits unchanged.
  - Either case: no carry/borrow; tick and adjust events in that cycle are dropped.
- keep=1 (and load=0): digits unchanged, tick and adjust events dropped; debounce logic keeps running.
- Net step:
  - step = tick_in + up_evt - down_evt, range -1..+2.
  - up_evt and down_evt together cancel.
  - digits <= (digits + step) mod MODULUS, computed in WIDTH+2 bits, no overflow.
- carry_out: asserted the cycle after an update with step > 0 that crossed MODULUS-1 -> 0, but only if tick_in contributed or CARRY_ON_ADJUST=1.
  - Example: MODULUS=60, digits=59, step=+2 -> digits=1, carry_out=1 when tick_in=1.
- borrow_out: asserted the cycle after a step of -1 from 0 to MODULUS-1, only if CARRY_ON_ADJUST=1.
- carry_out and borrow_out are never asserted together.
- bcd_tens/bcd_ones: registered together with digits, so they are always consistent with it (tens = digits/10, ones = digits%10).
- Out-of-range digits cannot arise.
- clear asserted mid-debounce or mid-pulse: everything returns to reset values immediately; no event is emitted on release of clear.

Decomposition:
- Package clock_pkg:
  - localparam CLK_MOD_SEC=60, CLK_MOD_MIN=60, CLK_MOD_HOUR=24.
  - typedef for the signed step (2-bit+sign).
  - function bin_to_bcd2 (WIDTH -> two nibbles).
- Sub-module adj_debounce (synchroniser + debounce + rising-edge pulse), parameter DEBOUNCE, ports clk, clear, btn_raw, evt.
- Instantiated twice, for adj_up and adj_down.

Test Plan:
- Reset: clear pulsed mid-count at digits=37 -> all outputs 0 asynchronously; 5 ticks after release -> digits=5, bcd 0/5.
- Wrap: MODULUS=60, load 58, two ticks -> digits 59 then 0; carry_out=1 for exactly one cycle after the wrap; bcd 5/9 then 0/0.
- Debounce (DEBOUNCE=4):
  - adj_up glitches high 2 cycles -> no change.
  - Held 10 cycles -> digits +1 exactly once, 6 cycles after the edge.
- Simultaneous events:
  - digits=59, tick_in and up_evt same cycle -> digits=1, carry_out=1.
  - up_evt and down_evt same cycle -> unchanged.
- Down-wrap: CARRY_ON_ADJUST=1, digits=0, adj_down event -> digits=59, borrow_out=1 one cycle; repeated with CARRY_ON_ADJUST=0 -> borrow_out stays 0.
- Keep/load: keep=1 with 3 ticks and an up event -> digits unchanged; load_val=60 -> ignored; load_val=23 with MODULUS=24 -> digits=23, bcd 2/3.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the modulo time-counter stages (seconds, minutes, hours).
package clock_pkg;

    localparam int CLK_MOD_SEC  = 60;
    localparam int CLK_MOD_MIN  = 60;
    localparam int CLK_MOD_HOUR = 24;

    // Net step of one update: tick + up - down, range -1..+2.
    typedef logic signed [2:0] step_t;

    // Binary (0..99) to packed BCD {tens, ones}.
    function automatic logic [7:0] bin_to_bcd2(input logic [7:0] bin);
        return ((bin / 8'd10) << 4) | (bin % 8'd10);
    endfunction

endpackage

// File: rtl/adj_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability debounce and a
// one-cycle pulse on each accepted press (release is silent).
module adj_debounce #(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic clear,
    input  logic btn_raw,
    output logic evt
);

    localparam int            CW       = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    logic          r_sync0;
    logic          r_sync1;
    logic          r_stable;
    logic          r_stable_d;
    logic [CW-1:0] r_cnt;

    // Bring the raw button into the clk domain.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
        end else begin
            r_sync0 <= btn_raw;
            r_sync1 <= r_sync0;
        end
    end

    // Accept a new level only after DEBOUNCE consecutive differing samples.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else if (r_sync1 == r_stable) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_stable <= r_sync1;
            r_cnt    <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Delayed stable level for rising-edge detection.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_stable_d <= 1'b0;
        end else begin
            r_stable_d <= r_stable;
        end
    end

    assign evt = r_stable & ~r_stable_d;

endmodule

// File: rtl/modn_time_counter.sv
// Modulo-MODULUS clock field counter with debounced adjust buttons, preset,
// registered wrap pulses and a registered BCD split of the count.
module modn_time_counter
    import clock_pkg::*;
#(
    parameter int MODULUS         = CLK_MOD_SEC,
    parameter int WIDTH           = 6,
    parameter int DEBOUNCE        = 4,
    parameter bit CARRY_ON_ADJUST = 1'b0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             tick_in,
    input  logic             keep,
    input  logic             adj_up,
    input  logic             adj_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] digits,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_ones,
    output logic             carry_out,
    output logic             borrow_out
);

    localparam int                SW    = WIDTH + 2;
    localparam logic signed [SW-1:0] MOD_S = SW'(MODULUS);

    logic                 w_up_evt;
    logic                 w_down_evt;
    step_t                w_step;
    logic signed [SW-1:0] w_sum;
    logic [WIDTH-1:0]     w_step_next;
    logic                 w_wrap_up;
    logic                 w_wrap_down;
    logic                 w_load_ok;
    logic [WIDTH-1:0]     w_d_next;
    logic                 w_carry_next;
    logic                 w_borrow_next;
    logic [7:0]           w_bcd;

    logic [WIDTH-1:0]     r_digits;
    logic [3:0]           r_tens;
    logic [3:0]           r_ones;
    logic                 r_carry;
    logic                 r_borrow;

    adj_debounce #(.DEBOUNCE(DEBOUNCE)) u_dbn_up (
        .clk     (clk),
        .clear   (clear),
        .btn_raw (adj_up),
        .evt     (w_up_evt)
    );

    adj_debounce #(.DEBOUNCE(DEBOUNCE)) u_dbn_down (
        .clk     (clk),
        .clear   (clear),
        .btn_raw (adj_down),
        .evt     (w_down_evt)
    );

    // Net step and modular wrap of the current count.
    always_comb begin
        w_step      = $signed({2'b00, tick_in}) + $signed({2'b00, w_up_evt})
                    - $signed({2'b00, w_down_evt});
        w_sum       = $signed({2'b00, r_digits}) + SW'(w_step);
        w_wrap_up   = 1'b0;
        w_wrap_down = 1'b0;
        if (w_sum < 0) begin
            w_step_next = WIDTH'(MODULUS - 1);
            w_wrap_down = 1'b1;
        end else if (w_sum >= MOD_S) begin
            w_step_next = WIDTH'(w_sum - MOD_S);
            w_wrap_up   = 1'b1;
        end else begin
            w_step_next = WIDTH'(w_sum);
        end
    end

    // Update priority: load, then keep, then net step.
    always_comb begin
        w_load_ok     = int'(load_val) < MODULUS;
        w_d_next      = r_digits;
        w_carry_next  = 1'b0;
        w_borrow_next = 1'b0;
        if (load) begin
            if (w_load_ok) begin
                w_d_next = load_val;
            end
        end else if (!keep) begin
            w_d_next      = w_step_next;
            w_carry_next  = w_wrap_up & (tick_in | CARRY_ON_ADJUST);
            w_borrow_next = w_wrap_down & CARRY_ON_ADJUST;
        end
        w_bcd = bin_to_bcd2(8'(w_d_next));
    end

    // Count, BCD split and wrap pulses registered together.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_digits <= '0;
            r_tens   <= '0;
            r_ones   <= '0;
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
        end else begin
            r_digits <= w_d_next;
            r_tens   <= w_bcd[7:4];
            r_ones   <= w_bcd[3:0];
            r_carry  <= w_carry_next;
            r_borrow <= w_borrow_next;
        end
    end

    assign digits     = r_digits;
    assign bcd_tens   = r_tens;
    assign bcd_ones   = r_ones;
    assign carry_out  = r_carry;
    assign borrow_out = r_borrow;

endmodule
